// File: rtl/fwd_hazard_pkg.sv
// Shared types for the forwarding/hazard controller:
// forward-select encoding, hazard FSM states, stage destination shadows.
package fwd_hazard_pkg;

  // Shadow rd field is sized for the widest supported register address.
  localparam int unsigned SH_AW = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_ALU = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_e;

  typedef struct packed {
    logic [SH_AW-1:0] rd;
    logic             we;
    logic             ld;
  } stage_shadow_t;

endpackage

// File: rtl/fwd_operand_mux.sv
// Single-channel 3:1 operand mux: regfile / write-back / ALU(M).
// Ports: sel_i, rf_i, wb_i, alu_i -> data_o. Select 2'b11 decodes as ALU.
module fwd_operand_mux
  import fwd_hazard_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      sel_i,
  input  logic [XLEN-1:0] rf_i,
  input  logic [XLEN-1:0] wb_i,
  input  logic [XLEN-1:0] alu_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    data_o = alu_i;
    unique case (sel_i)
      FWD_RF:  data_o = rf_i;
      FWD_WB:  data_o = wb_i;
      default: data_o = alu_i;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding + hazard controller: E/M/W dest shadows, registered
// per-channel forward selects, load-use stall, mem-wait freeze, flush.
// Ports: Decode info (id_*), flush, mem handshake, E/M/W data in;
// operand_E_o, fwd_sel_E_o, stall_F_o, stall_D_o, bubble_E_o, freeze_o.
// Option FWD_HAZARD_PERF_EN: adds lu_stall_cnt_o / mem_wait_cnt_o.
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_AW  = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_addr_i,
  input  logic [REG_AW-1:0]         id_rd_addr_i,
  input  logic                      id_rd_we_i,
  input  logic                      id_is_load_i,
  input  logic                      ex_flush_i,
  input  logic                      mem_ready_i,
  input  logic                      mem_op_M_i,
  input  logic [NUM_SRC*XLEN-1:0]   rs_data_E_i,
  input  logic [XLEN-1:0]           alu_data_M_i,
  input  logic [XLEN-1:0]           wb_data_W_i,
  output logic [NUM_SRC*XLEN-1:0]   operand_E_o,
  output logic [NUM_SRC*2-1:0]      fwd_sel_E_o,
`ifdef FWD_HAZARD_PERF_EN
  output logic [31:0]               lu_stall_cnt_o,
  output logic [31:0]               mem_wait_cnt_o,
`endif
  output logic                      stall_F_o,
  output logic                      stall_D_o,
  output logic                      bubble_E_o,
  output logic                      freeze_o
);

  stage_shadow_t e_q, e_d;
  stage_shadow_t m_q, m_d;
  stage_shadow_t w_q, w_d;

  logic [NUM_SRC*2-1:0] sel_q, sel_d, sel_dec;
  hz_state_e            state_q, state_d;

  logic [NUM_SRC-1:0] e_hit, e_ld_hit, m_hit;
  logic frozen, lu_hz, lu_stall, bubble;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_ch
    logic [SH_AW-1:0] rs;
    logic             nz;

    assign rs = SH_AW'(id_rs_addr_i[k*REG_AW +: REG_AW]);
    assign nz = id_valid_i & (|rs);

    assign e_hit[k]    = nz & e_q.we & ~e_q.ld & (e_q.rd == rs);
    assign e_ld_hit[k] = nz & e_q.ld & (e_q.rd == rs);
    assign m_hit[k]    = nz & m_q.we & (m_q.rd == rs);

    // Youngest producer wins: E before M.
    assign sel_dec[2*k +: 2] = e_hit[k] ? FWD_ALU
                             : m_hit[k] ? FWD_WB
                             : FWD_RF;

    fwd_operand_mux #(
      .XLEN (XLEN)
    ) u_mux (
      .sel_i  (sel_q[2*k +: 2]),
      .rf_i   (rs_data_E_i[k*XLEN +: XLEN]),
      .wb_i   (wb_data_W_i),
      .alu_i  (alu_data_M_i),
      .data_o (operand_E_o[k*XLEN +: XLEN])
    );
  end

  assign frozen   = mem_op_M_i & ~mem_ready_i;
  assign lu_hz    = id_valid_i & (|e_ld_hit);
  assign lu_stall = ~frozen & lu_hz & ~ex_flush_i;
  assign bubble   = lu_stall | (~frozen & ex_flush_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = RUN;
    unique case (1'b1)
      frozen:   state_d = MEM_WAIT;
      lu_stall: state_d = LU_STALL;
      default:  state_d = RUN;
    endcase
  end

  // Gated by rst_ni so outputs drop at once on an async reset,
  // even while the memory still reports a pending access.
  always_comb begin
    stall_F_o  = 1'b0;
    stall_D_o  = 1'b0;
    bubble_E_o = 1'b0;
    freeze_o   = 1'b0;
    if (rst_ni) begin
      stall_F_o  = lu_stall;
      stall_D_o  = lu_stall;
      bubble_E_o = bubble;
      freeze_o   = frozen;
    end
  end

  always_comb begin
    e_d   = e_q;
    m_d   = m_q;
    w_d   = w_q;
    sel_d = sel_q;
    if (!frozen) begin
      w_d    = m_q;
      w_d.ld = 1'b0;
      m_d    = e_q;
      e_d.rd = SH_AW'(id_rd_addr_i);
      e_d.we = id_valid_i & id_rd_we_i;
      e_d.ld = id_valid_i & id_is_load_i;
      sel_d  = sel_dec;
      if (bubble) begin
        e_d   = '0;
        sel_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      sel_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      sel_q <= sel_d;
    end
  end

  assign fwd_sel_E_o = sel_q;

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] lu_cnt_q, lu_cnt_d;
  logic [31:0] mw_cnt_q, mw_cnt_d;

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    mw_cnt_d = mw_cnt_q;
    if ((state_q == LU_STALL) && (lu_cnt_q != '1)) begin
      lu_cnt_d = lu_cnt_q + 32'd1;
    end
    if ((state_q == MEM_WAIT) && (mw_cnt_q != '1)) begin
      mw_cnt_d = mw_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lu_cnt_q <= '0;
      mw_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      mw_cnt_q <= mw_cnt_d;
    end
  end

  assign lu_stall_cnt_o = lu_cnt_q;
  assign mem_wait_cnt_o = mw_cnt_q;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard controller for the 5-stage pipeline: generalises the two-way Execute-stage operand mux to `NUM_SRC` operand channels. It adds internal destination tracking for the E/M/W stages, registered forward selects, load-use stall insertion, data-memory wait freeze and branch-flush handling. It sits beside the Decode/Execute pipeline registers and drives the operand inputs of the ALU and store-data path.

## Interface
- `XLEN`, 32, data width
- `NUM_SRC`, 2, number of source-operand channels (rs1, rs2, ...)
- `REG_AW`, 5, register-address width
- `clk_i` in 1, pipeline clock
- `rst_ni` in 1, asynchronous active-low reset
- `id_valid_i` in 1, Decode holds a valid instruction
- `id_rs_addr_i` in NUM_SRC*REG_AW, Decode source addresses; channel k at [k*REG_AW +: REG_AW]
- `id_rd_addr_i` in REG_AW, Decode destination
- `id_rd_we_i` in 1, Decode instruction writes rd
- `id_is_load_i` in 1, Decode instruction is a load
- `ex_flush_i` in 1, branch mispredict resolved in E: kill the instruction in D
- `mem_ready_i` in 1, data memory done; when low with a memory op in M, the pipe freezes
- `mem_op_M_i` in 1, M holds a load/store
- `rs_data_E_i` in NUM_SRC*XLEN, register-file operands in E
- `alu_data_M_i` in XLEN, ALU result in M
- `wb_data_W_i` in XLEN, write-back data in W
- `operand_E_o` out NUM_SRC*XLEN, forwarded operands
- `fwd_sel_E_o` out NUM_SRC*2, per-channel select: 2'b10 = M, 2'b01 = W, 2'b00 = regfile
- `stall_F_o`, `stall_D_o` out 1, hold PC and the IF/ID register
- `bubble_E_o` out 1, load ID/EX with a NOP
- `freeze_o` out 1, hold all pipeline registers

## Operation
- Shadow registers per stage: E {rd, we, ld}, M {rd, we, ld}, W {rd, we}. They advance each cycle unless frozen. A bubble or flush loads E with we=0, ld=0.
- Forward decision is made in D for each channel k with `rs` = `id_rs_addr_i[k]`:
  - rs==0 -> 00.
  - Otherwise, a match on the E shadow (we=1, ld=0) -> 10.
  - Otherwise, a match on the M shadow (we=1) -> 01.
  - Otherwise 00.
  - The result is registered into `fwd_sel_E_o`. The E match has priority over M (youngest wins).
- A match in the W shadow needs no forwarding: the register file is write-through.
- Load-use: `id_valid_i` and any channel with rs≠0 matching the E shadow with ld=1 -> state LU_STALL.
- FSM states: RUN, LU_STALL, MEM_WAIT.
  - RUN -> MEM_WAIT when `mem_op_M_i & ~mem_ready_i`. This has priority over load-use.
  - RUN -> LU_STALL on a load-use hazard with `ex_flush_i`=0.
  - LU_STALL asserts `stall_F_o`, `stall_D_o` and `bubble_E_o` for exactly one cycle. The fwd_sel for the bubble is 00. Then -> RUN, and D is re-evaluated: the load is now in M, so the consumer gets select 01.
  - MEM_WAIT asserts `freeze_o`. Shadows and `fwd_sel_E_o` hold. Exits to RUN the cycle after `mem_ready_i`=1.
- Flush: `ex_flush_i` in RUN cancels any load-use stall and loads E with a bubble. `ex_flush_i` is ignored while frozen; the branch unit holds it.
- `operand_E_o[k]` is a combinational mux of `rs_data_E_i[k]`, `wb_data_W_i` and `alu_data_M_i`, driven by the registered select. 2'b11 is illegal and decodes as M.

## Timing
- Reset:
  - All shadows are cleared (we=0).
  - `fwd_sel_E_o`=0 and state=RUN.
  - `stall_F_o`, `stall_D_o`, `bubble_E_o` and `freeze_o` are all 0.
- Select latency: 1 cycle (D decision -> E select). Operand path: 0 cycles from select/data.
- Stall/bubble/freeze outputs are combinational from the state and current inputs, so they are valid in the same cycle as the hazard.
- A reset assertion mid-stall or mid-freeze returns immediately to RUN with all outputs 0.

## Configuration
- `FWD_HAZARD_PERF_EN` defined adds two outputs, both saturating at 2^32-1 and reset to 0:
  - `lu_stall_cnt_o` [31:0] increments on each LU_STALL cycle.
  - `mem_wait_cnt_o` [31:0] increments on each MEM_WAIT cycle.
- Not defined: the ports and counters are absent.

## Structure
- Shared package `fwd_hazard_pkg` holds:
  - the `fwd_sel_e` enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_ALU=2'b10);
  - the `hz_state_e` enum;
  - the `stage_shadow_t` struct {rd, we, ld}.
- One sub-module, `fwd_operand_mux`, a single-channel XLEN 3:1 mux, instantiated NUM_SRC times via generate.

## Test plan
- `add x5` then `sub x6,x5,x1` back-to-back -> next cycle `fwd_sel_E_o`[1:0]=10 and operand0 = `alu_data_M_i` (0x1234).
- `add x5`, an unrelated instruction, then a consumer of x5 -> select 01 and operand = `wb_data_W_i`.
- `lw x7` then `and x8,x7,x7` -> one cycle with stall_F/D=1 and bubble_E=1, then both channels select 01. No stall on `lw x0` followed by a consumer of x0.
- Load-use hazard with `ex_flush_i`=1 in the same cycle -> no stall, bubble_E=1.
- Store in M with `mem_ready_i` low for 3 cycles -> freeze_o=1 for 3 cycles, selects held; with `FWD_HAZARD_PERF_EN`, mem_wait_cnt_o=3.
- Assert `rst_ni`=0 during MEM_WAIT -> all outputs 0 asynchronously, state RUN after release.
